// File: rtl/drsstc_pkg.sv
// Shared types and helpers for the DRSSTC timing blocks.
// Latency: none, package only.
// Backpressure: not applicable.
package drsstc_pkg;

    // Period-meter FSM: IDLE waits for a reference edge, MEASURE counts since the last edge.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

    // Lock qualification defaults.
    localparam int unsigned LOCK_COUNT_DEF = 4;
    localparam int unsigned TOLERANCE_DEF  = 2;

    // Absolute difference between two output codes.
    function automatic int unsigned code_delta(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/defines.sv
// Shared width and integer-division macros for the drive-control blocks.
// Latency: none, text macros only.
// Backpressure: not applicable.
`ifndef DEFINES_SV
`define DEFINES_SV

// Bits needed to hold every value from 0 up to and including x.
`define WIDTH(x) ($clog2((x) + 1))

// Integer division; truncates toward zero, as the generator block does.
`define DIV(a, b) ((a) / (b))

`endif

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a both-edge detector.
// Latency: an input transition shows up as edge_o two to three clk cycles later.
// Backpressure: none; edge_o is a free-running one-cycle pulse.
// Ports: clk/rst (sync, active-high), async_i (asynchronous level), edge_o (one-cycle pulse per transition).
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    // Any difference between the synchronized level and its previous value is an edge.
    assign edge_o = sync_q ^ hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the half-period of a square-wave feedback signal and converts it to a generator code.
// Latency: code/valid/err_* update one clk after the detected edge (or after the timeout).
// Backpressure: none; outputs are one-cycle strobes with code held between updates.
// Ports: clk, rst (sync, active-high), sig (async feedback), code (half-period code),
//        valid (code updated), locked (stable frequency), err_fast / err_slow (range error strobes).
`include "defines.sv"

module period_meter
    import drsstc_pkg::*;
#(
    parameter int unsigned CLK_MHZ       = 100,
    parameter int unsigned FREQ_KHZ_MIN  = 100,
    parameter int unsigned FREQ_KHZ_MAX  = 400,
    parameter int unsigned GEN_PARAMETER = 255,
    parameter int unsigned LOCK_COUNT    = LOCK_COUNT_DEF,
    parameter int unsigned TOLERANCE     = TOLERANCE_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sig,
    output logic [`WIDTH(GEN_PARAMETER)-1:0]  code,
    output logic                              valid,
    output logic                              locked,
    output logic                              err_fast,
    output logic                              err_slow
);

    localparam int unsigned CNT_MIN = `DIV(500 * CLK_MHZ, FREQ_KHZ_MAX);
    localparam int unsigned CNT_MAX = `DIV(500 * CLK_MHZ, FREQ_KHZ_MIN);
    localparam int unsigned CW      = $clog2(CNT_MAX + 2);
    localparam int unsigned W       = `WIDTH(GEN_PARAMETER);
    localparam int unsigned MW      = $clog2(LOCK_COUNT + 1);

    logic           edge_pulse;
    meas_state_e    state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [MW-1:0]  match_q;
    logic [MW-1:0]  match_d;
    logic [W-1:0]   code_q;
    logic [W-1:0]   code_d;
    logic           valid_q;
    logic           locked_q;
    logic           fast_q;
    logic           slow_q;
    logic           too_fast;
    logic           timeout;
    logic           in_tol;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (sig),
        .edge_o  (edge_pulse)
    );

    always_comb begin
        too_fast = 32'(cnt_q) < CNT_MIN;
        timeout  = cnt_q == CW'(CNT_MAX + 1);

        // Half-periods beyond the code range clamp to full scale.
        if (32'(cnt_q) >= CNT_MIN + GEN_PARAMETER) begin
            code_d = W'(GEN_PARAMETER);
        end else begin
            code_d = W'(32'(cnt_q) - CNT_MIN);
        end

        // After an error or reset match_q is 0, so an increment and a restart both give 1;
        // that is why no separate "previous code exists" flag is kept.
        in_tol = code_delta(32'(code_d), 32'(code_q)) <= TOLERANCE;
        if (!in_tol) begin
            match_d = MW'(1);
        end else if (match_q >= MW'(LOCK_COUNT)) begin
            match_d = match_q;
        end else begin
            match_d = match_q + MW'(1);
        end

        cnt_d = timeout ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            fast_q  <= 1'b0;
            slow_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (edge_pulse) begin
                        cnt_q   <= CW'(1);
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // Edge is checked first so a coincident timeout is ignored.
                    if (edge_pulse) begin
                        cnt_q <= CW'(1);
                        if (too_fast) begin
                            fast_q   <= 1'b1;
                            match_q  <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            valid_q  <= 1'b1;
                            code_q   <= code_d;
                            match_q  <= match_d;
                            locked_q <= match_d == MW'(LOCK_COUNT);
                        end
                    end else if (timeout) begin
                        slow_q   <= 1'b1;
                        match_q  <= '0;
                        locked_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign err_fast = fast_q;
    assign err_slow = slow_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: half-period stimulus drives a reference model
// that queues expected output events; a monitor pops and compares each DUT strobe.
// Ports: none (top-level bench).
module tb_period_meter;

    localparam int CNT_MIN = 125;
    localparam int CNT_MAX = 500;
    localparam int GEN     = 255;
    localparam int LOCKN   = 4;
    localparam int TOL     = 2;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FAST  = 3'b010;
    localparam logic [2:0] K_SLOW  = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig;
    logic [7:0] code;
    logic       valid;
    logic       locked;
    logic       err_fast;
    logic       err_slow;

    always #5 clk = ~clk;

    period_meter dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .code     (code),
        .valid    (valid),
        .locked   (locked),
        .err_fast (err_fast),
        .err_slow (err_slow)
    );

    typedef struct {
        logic [2:0] kind;
        int         code;
        logic       locked;
        int         gap;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: measuring flag, last valid code, consecutive-match count.
    bit m_meas    = 1'b0;
    bit m_had_out = 1'b0;
    int m_code    = 0;
    int m_match   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] kind, input int c, input logic lk, input int gap);
        exp_t e;
        e.kind   = kind;
        e.code   = c;
        e.locked = lk;
        e.gap    = gap;
        expq.push_back(e);
    endtask

    // An edge that closes a half-period of h clock cycles.
    task automatic model_edge(input int h);
        int c;
        int d;
        if (!m_meas) begin
            m_meas    = 1'b1;
            m_had_out = 1'b0;
        end else if (h < CNT_MIN) begin
            m_match = 0;
            push(K_FAST, m_code, 1'b0, 0);
            m_had_out = 1'b1;
        end else begin
            c = (h - CNT_MIN > GEN) ? GEN : h - CNT_MIN;
            d = (c > m_code) ? c - m_code : m_code - c;
            if (d <= TOL) m_match = (m_match < LOCKN) ? m_match + 1 : LOCKN;
            else          m_match = 1;
            m_code = c;
            push(K_VALID, c, m_match == LOCKN, 0);
            m_had_out = 1'b1;
        end
    endtask

    // Hold sig for L cycles, then toggle it. Holds longer than CNT_MAX+1 time out first.
    task automatic do_half(input int L);
        if (m_meas && L >= CNT_MAX + 2) begin
            push(K_SLOW, m_code, 1'b0, m_had_out ? CNT_MAX + 1 : 0);
            m_meas  = 1'b0;
            m_match = 0;
        end
        repeat (L) @(posedge clk);
        #1 sig = ~sig;
        model_edge(L);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"},   int'(code),     0);
        check({tag, "_valid"},  int'(valid),    0);
        check({tag, "_locked"}, int'(locked),   0);
        check({tag, "_fast"},   int'(err_fast), 0);
        check({tag, "_slow"},   int'(err_slow), 0);
    endtask

    // Monitor: every strobe must match the next queued expectation.
    int   cyc      = 0;
    int   last_cyc = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (valid || err_fast || err_slow) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got valid=%0b fast=%0b slow=%0b code=%0d, expected no strobe at %0t",
                             valid, err_fast, err_slow, code, $time);
                end else begin
                    mon_e = expq.pop_front();
                    check("kind",   int'({valid, err_fast, err_slow}), int'(mon_e.kind));
                    check("code",   int'(code),   mon_e.code);
                    check("locked", int'(locked), int'(mon_e.locked));
                    if (mon_e.gap != 0) check("slow_gap", cyc - last_cyc, mon_e.gap);
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        int L;
        int r;
        sig = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        // Reference edge, then steady 325-cycle half-periods: code 200, lock on 4th valid.
        do_half(50);
        for (int i = 0; i < 8; i++) do_half(325);

        // One 330 half-period breaks lock, then steady 325 relocks.
        do_half(330);
        for (int i = 0; i < 6; i++) do_half(325);

        // Static input: single err_slow, back to IDLE, code held.
        do_half(700);
        do_half(325);

        // Range boundaries and the too-fast case.
        for (int i = 0; i < 3; i++) do_half(125);
        for (int i = 0; i < 3; i++) do_half(380);
        for (int i = 0; i < 3; i++) do_half(450);
        for (int i = 0; i < 4; i++) do_half(100);
        for (int i = 0; i < 2; i++) do_half(325);

        // Reset mid-half-period with sig low; first edge after release only re-arms.
        if (sig) do_half(325);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("midreset");
        m_meas  = 1'b0;
        m_match = 0;
        m_code  = 0;
        do_half(150);
        do_half(325);
        do_half(325);

        // Randomized half-periods: wide range, timeouts, and near-325 jitter for locking.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      L = int'($urandom_range(60, 480));
            else if (r == 1) L = int'($urandom_range(600, 700));
            else             L = int'($urandom_range(320, 328));
            do_half(L);
        end

        repeat (20) @(posedge clk);
        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
